// File: rtl/spart_rx_fifo_pkg.sv
// Shared SPART constants: data width, idle byte and receive FIFO defaults.
package spart_rx_fifo_pkg;

  localparam int unsigned SPART_DATA_W        = 8;
  localparam logic [7:0]  SPART_IDLE_BYTE     = 8'hFF;
  localparam int unsigned SPART_FIFO_DEPTH    = 16;
  localparam int unsigned SPART_FIFO_AF_LEVEL = 12;

endpackage : spart_rx_fifo_pkg

// File: rtl/spart_rx_fifo_if.sv
// Receiver-to-consumer bus around the SPART receive FIFO.
interface spart_rx_fifo_if #(
  parameter int unsigned DEPTH = spart_rx_fifo_pkg::SPART_FIFO_DEPTH
) ();

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [spart_rx_fifo_pkg::SPART_DATA_W-1:0] rx_data;
  logic                                       rda;
  logic                                       rd_en;
  logic                                       ovr_clr;
  logic [spart_rx_fifo_pkg::SPART_DATA_W-1:0] rd_data;
  logic                                       empty;
  logic                                       full;
  logic                                       almost_full;
  logic [CW-1:0]                              count;
  logic                                       overrun;

  // Driver side: receiver plus consumer.
  modport master (
    output rx_data, rda, rd_en, ovr_clr,
    input  rd_data, empty, full, almost_full, count, overrun
  );

  // FIFO side.
  modport slave (
    input  rx_data, rda, rd_en, ovr_clr,
    output rd_data, empty, full, almost_full, count, overrun
  );

endinterface : spart_rx_fifo_if

// File: rtl/spart_fifo_mem.sv
// DEPTH x 8 register array: one synchronous write port, one asynchronous read port.
module spart_fifo_mem
  import spart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = SPART_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      i_we,
  input  logic [$clog2(DEPTH)-1:0]  i_waddr,
  input  logic [SPART_DATA_W-1:0]   i_wdata,
  input  logic [$clog2(DEPTH)-1:0]  i_raddr,
  output logic [SPART_DATA_W-1:0]   o_rdata
);

  logic [SPART_DATA_W-1:0] r_mem [DEPTH];

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : spart_fifo_mem

// File: rtl/spart_rx_fifo.sv
// SPART receive byte FIFO: first-word-fall-through, occupancy flags, sticky overrun.
module spart_rx_fifo
  import spart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH    = SPART_FIFO_DEPTH,
  parameter int unsigned AF_LEVEL = SPART_FIFO_AF_LEVEL
) (
  input  logic           clk,
  input  logic           rst_n,
  spart_rx_fifo_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic                    r_overrun;
  logic                    w_empty;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_drop;
  logic [SPART_DATA_W-1:0] w_mem_rdata;

  assign w_empty = (r_count == CW'(0));
  assign w_full  = (r_count == CW'(DEPTH));

  // A pop frees a slot in the same cycle, so a push into a full queue succeeds alongside it.
  assign w_pop  = bus.rd_en && !w_empty;
  assign w_push = bus.rda && (!w_full || w_pop);
  assign w_drop = bus.rda && w_full && !w_pop;

  // Pointer and occupancy state; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Sticky overrun; a new drop takes priority over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (bus.ovr_clr) begin
      r_overrun <= 1'b0;
    end
  end

  spart_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.rx_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rdata)
  );

  assign bus.rd_data     = w_empty ? SPART_IDLE_BYTE : w_mem_rdata;
  assign bus.empty       = w_empty;
  assign bus.full        = w_full;
  assign bus.almost_full = (r_count >= CW'(AF_LEVEL));
  assign bus.count       = r_count;
  assign bus.overrun     = r_overrun;

endmodule : spart_rx_fifo
